// File: rtl/cpu_bus_rd_responder.sv
// cpu_bus_rd_responder: turns CPU read strobes into one-shot bank read requests
// and presents the returned word on CPU_DATA through an output enable.
module cpu_bus_rd_responder #(
   parameter int unsigned READ_LATENCY  = 2,
   parameter int unsigned TURN_CYCLES   = 1,
   parameter logic [3:0]  READABLE_MASK = 4'b0001
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        EN,
   input  logic        RD,
   input  logic        RDWR,
   input  logic [1:0]  BRAM_SELECT,
   input  logic [13:0] BRAM_ADDR,
   output logic        RD_REQ,
   output logic [1:0]  RD_SEL,
   output logic [13:0] RD_ADDR,
   input  logic [15:0] RD_DATA,
   output logic [15:0] DATA_OUT,
   output logic        DATA_OE,
   output logic [7:0]  ABORT_CNT
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRIVE, TURN} state_t;
   state_t      state;
   logic        s, s_q, armed, start;
   logic [2:0]  cnt;
   logic [1:0]  tcnt;
   assign s     = EN & RD & RDWR;
   // armed masks the first edge after reset so a level held through release is not a start
   assign start = s & ~s_q & armed;
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         s_q       <= 1'b0;
         armed     <= 1'b0;
         cnt       <= 3'd0;
         tcnt      <= 2'd0;
         RD_REQ    <= 1'b0;
         RD_SEL    <= 2'd0;
         RD_ADDR   <= 14'd0;
         DATA_OUT  <= 16'h0000;
         DATA_OE   <= 1'b0;
         ABORT_CNT <= 8'd0;
      end else begin
         s_q    <= s;
         armed  <= 1'b1;
         RD_REQ <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state   <= ISSUE;
               RD_SEL  <= BRAM_SELECT;
               RD_ADDR <= BRAM_ADDR;
               RD_REQ  <= READABLE_MASK[BRAM_SELECT];
            end
            ISSUE, WAIT: if (!s) begin
               state     <= TURN;
               tcnt      <= TURN_CYCLES[1:0];
               ABORT_CNT <= (ABORT_CNT == 8'hFF) ? ABORT_CNT : ABORT_CNT + 8'd1;
            end else if (state == ISSUE) begin
               state <= WAIT;
               cnt   <= READ_LATENCY[2:0];
            end else if (cnt == 3'd1) begin
               state    <= DRIVE;
               DATA_OUT <= READABLE_MASK[RD_SEL] ? RD_DATA : 16'h0000;
               DATA_OE  <= 1'b1;
            end else begin
               cnt <= cnt - 3'd1;
            end
            DRIVE: if (!s) begin
               state   <= TURN;
               tcnt    <= TURN_CYCLES[1:0];
               DATA_OE <= 1'b0;
            end
            TURN: if (tcnt <= 2'd1) state <= IDLE;
                  else tcnt <= tcnt - 2'd1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_bus_rd_responder.sv
// tb_cpu_bus_rd_responder: directed and randomized read transactions checked
// against a transaction-level model of the responder.
module tb_cpu_bus_rd_responder;
   localparam int unsigned L    = 2;
   localparam int unsigned TC   = 1;
   localparam logic [3:0]  MASK = 4'b0001;
   logic        CLK, RESET_N, EN, RD, RDWR, RD_REQ, DATA_OE;
   logic [1:0]  BRAM_SELECT, RD_SEL;
   logic [13:0] BRAM_ADDR, RD_ADDR;
   logic [15:0] RD_DATA, DATA_OUT;
   logic [7:0]  ABORT_CNT;
   int          vectors = 0;
   int          errors  = 0;
   int          exp_aborts = 0;
   logic [15:0] exp_out = 16'h0000;
   cpu_bus_rd_responder #(.READ_LATENCY(L), .TURN_CYCLES(TC), .READABLE_MASK(MASK)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .RD(RD), .RDWR(RDWR),
      .BRAM_SELECT(BRAM_SELECT), .BRAM_ADDR(BRAM_ADDR), .RD_REQ(RD_REQ),
      .RD_SEL(RD_SEL), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .DATA_OUT(DATA_OUT),
      .DATA_OE(DATA_OE), .ABORT_CNT(ABORT_CNT)
   );
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [7:0] sat_aborts();
      return (exp_aborts > 255) ? 8'hFF : 8'(exp_aborts);
   endfunction
   // One CPU read: strobe rises in the current cycle; drop>0 releases RD that many cycles in (abort).
   // rel picks which term ends the read (0 RD, 1 EN, 2 RDWR); again re-raises the strobe during turnaround.
   task automatic read_txn(input logic [1:0] sel, input logic [13:0] addr, input logic [15:0] data,
                           input int hold, input int drop, input int rel, input bit again);
      logic        rdbl;
      logic [15:0] word;
      rdbl = MASK[sel];
      word = rdbl ? data : 16'h0000;
      BRAM_SELECT = sel; BRAM_ADDR = addr; EN = 1'b1; RDWR = 1'b1; RD = 1'b1;
      RD_DATA = data ^ (16'($urandom) | 16'h0001);
      for (int c = 1; c <= int'(L) + 1; c++) begin
         tick();
         if (c == 1) begin
            chk("rd_req_issue", RD_REQ, rdbl);
            if (rdbl) begin
               chk("rd_sel", RD_SEL, sel);
               chk("rd_addr", RD_ADDR, addr);
            end
            BRAM_SELECT = ~sel; BRAM_ADDR = ~addr;
         end else chk("rd_req_single", RD_REQ, 1'b0);
         chk("oe_early", DATA_OE, 1'b0);
         if (c == drop) RD = 1'b0;
         RD_DATA = (c == int'(L) + 1) ? data : data ^ (16'($urandom) | 16'h0001);
      end
      tick();
      RD_DATA = 16'($urandom);
      if (drop > 0) begin
         exp_aborts++;
         chk("abort_oe", DATA_OE, 1'b0);
         chk("abort_out", DATA_OUT, exp_out);
         chk("abort_cnt", ABORT_CNT, sat_aborts());
         tick();
         chk("abort_oe_late", DATA_OE, 1'b0);
         return;
      end
      chk("oe_rise", DATA_OE, 1'b1);
      chk("data_out", DATA_OUT, word);
      exp_out = word;
      for (int h = 0; h < hold; h++) begin
         tick();
         RD_DATA = 16'($urandom);
         chk("oe_hold", DATA_OE, 1'b1);
         chk("data_hold", DATA_OUT, word);
      end
      if (rel == 1) EN = 1'b0; else if (rel == 2) RDWR = 1'b0; else RD = 1'b0;
      tick();
      chk("oe_release", DATA_OE, 1'b0);
      chk("out_keep", DATA_OUT, word);
      EN = 1'b1; RDWR = 1'b1; RD = again;
      tick();
      chk("abort_cnt_idle", ABORT_CNT, sat_aborts());
   endtask
   initial begin
      RESET_N = 1'b1; EN = 1'b0; RD = 1'b0; RDWR = 1'b0;
      BRAM_SELECT = 2'd0; BRAM_ADDR = 14'd0; RD_DATA = 16'h0000;
      #2 RESET_N = 1'b0;
      #2;
      chk("rst_req", RD_REQ, 1'b0);
      chk("rst_sel", RD_SEL, 2'd0);
      chk("rst_addr", RD_ADDR, 14'd0);
      chk("rst_out", DATA_OUT, 16'h0000);
      chk("rst_oe", DATA_OE, 1'b0);
      chk("rst_abort", ABORT_CNT, 8'd0);
      tick(); tick();
      #3 RESET_N = 1'b1;
      tick(); tick();
      read_txn(2'd0, 14'h0010, 16'hBEEF, 2, 0, 0, 1'b0);
      read_txn(2'd2, 14'h0123, 16'h1234, 1, 0, 0, 1'b0);
      read_txn(2'd0, 14'h0ABC, 16'hCAFE, 0, 2, 0, 1'b0);
      // strobe re-raised during turnaround must be dropped
      read_txn(2'd0, 14'h0200, 16'h5A5A, 0, 0, 0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("turn_drop_req", RD_REQ, 1'b0);
         chk("turn_drop_oe", DATA_OE, 1'b0);
      end
      RD = 1'b0;
      tick();
      read_txn(2'd0, 14'h0201, 16'hA5A5, 1, 0, 1, 1'b0);
      EN = 1'b1; RD = 1'b1; RDWR = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wr_req", RD_REQ, 1'b0);
         chk("wr_oe", DATA_OE, 1'b0);
      end
      RD = 1'b0; tick(); RDWR = 1'b1; tick();
      for (int i = 0; i < 256; i++)
         read_txn(2'(i), 14'(i), 16'($urandom), 0, 1, 0, 1'b0);
      chk("abort_sat", ABORT_CNT, 8'hFF);
      read_txn(2'd0, 14'h0042, 16'h0F0F, 0, 3, 0, 1'b0);
      chk("abort_sat_hold", ABORT_CNT, 8'hFF);
      // asynchronous reset while driving, strobe held through release
      BRAM_SELECT = 2'd0; BRAM_ADDR = 14'h0777; EN = 1'b1; RDWR = 1'b1; RD = 1'b1;
      for (int c = 1; c <= int'(L) + 2; c++) begin
         tick();
         RD_DATA = (c == int'(L) + 1) ? 16'h7E57 : 16'h0000;
      end
      chk("pre_rst_oe", DATA_OE, 1'b1);
      chk("pre_rst_out", DATA_OUT, 16'h7E57);
      #2 RESET_N = 1'b0;
      #1;
      chk("async_rst_oe", DATA_OE, 1'b0);
      chk("async_rst_out", DATA_OUT, 16'h0000);
      chk("async_rst_abort", ABORT_CNT, 8'd0);
      exp_out = 16'h0000; exp_aborts = 0;
      #1 RESET_N = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("held_level_req", RD_REQ, 1'b0);
         chk("held_level_oe", DATA_OE, 1'b0);
      end
      RD = 1'b0; tick();
      read_txn(2'd0, 14'h1FFF, 16'hFACE, 1, 0, 2, 1'b0);
      for (int i = 0; i < 40; i++) begin
         logic [1:0] sel;
         sel = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
         read_txn(sel, 14'($urandom), 16'($urandom), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, L + 1) : 0,
                  $urandom_range(0, 2), 1'b0);
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
      chk("final_abort_cnt", ABORT_CNT, sat_aborts());
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
